// File: rtl/ota_bitstream_decimator.sv
// Accumulate-and-dump decimator for the OTA comparator bitstream: sync, count ones over 2^WIN_LOG2 clocks, flag stuck loops.
// Define OTA_DECIM_DEGLITCH_EN to insert a 3-tap majority filter after the synchroniser.
module ota_bitstream_decimator #(
    parameter int WIN_LOG2    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       en,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic       sat,
    output logic       stuck,
    output logic       busy
);
    localparam int N  = 1 << WIN_LOG2;
    localparam int CW = WIN_LOG2 + 1;
`ifdef OTA_DECIM_DEGLITCH_EN
    localparam int SETTLE_LEN = SYNC_STAGES + 2;
`else
    localparam int SETTLE_LEN = SYNC_STAGES;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACC    = 2'd2
    } state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sync_p0;
    logic                    sync_out;
    logic                    b_s;
    logic                    b_prev;
    logic [CW-1:0]           acc;
    logic [CW-1:0]           trn;
    logic [WIN_LOG2-1:0]     phase;
    logic [2:0]              settle_cnt;
    logic [CW-1:0]           acc_final;
    logic [CW-1:0]           trn_final;

    // Clip a window count to the largest value representable in WIN_LOG2 bits.
    function automatic logic [7:0] clip_count(input logic [CW-1:0] cnt);
        logic [7:0] r;
        r = '0;
        if (cnt >= CW'(N))
            r[WIN_LOG2-1:0] = '1;
        else
            r[WIN_LOG2-1:0] = cnt[WIN_LOG2-1:0];
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], bit_in};
        end
    end

    assign sync_out = sync_p0[SYNC_STAGES-1];

`ifdef OTA_DECIM_DEGLITCH_EN
    logic dg_p1;
    logic dg_p2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dg_p1 <= 1'b0;
            dg_p2 <= 1'b0;
        end else begin
            dg_p1 <= sync_out;
            dg_p2 <= dg_p1;
        end
    end

    assign b_s = (sync_out & dg_p1) | (sync_out & dg_p2) | (dg_p1 & dg_p2);
`else
    assign b_s = sync_out;
`endif

    // Transition reference; during SETTLE this primes the first ACC comparison.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_prev <= 1'b0;
        end else begin
            b_prev <= b_s;
        end
    end

    assign acc_final = acc + CW'(b_s);
    assign trn_final = trn + CW'(b_s ^ b_prev);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            sample       <= '0;
            sample_valid <= 1'b0;
            sat          <= 1'b0;
            stuck        <= 1'b0;
            busy         <= 1'b0;
            acc          <= '0;
            trn          <= '0;
            phase        <= '0;
            settle_cnt   <= '0;
        end else begin
            sample_valid <= 1'b0;
            if (!en) begin
                state      <= IDLE;
                busy       <= 1'b0;
                acc        <= '0;
                trn        <= '0;
                phase      <= '0;
                settle_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state      <= SETTLE;
                        busy       <= 1'b1;
                        settle_cnt <= '0;
                    end
                    SETTLE: begin
                        if (settle_cnt == 3'(SETTLE_LEN - 1)) begin
                            state <= ACC;
                            acc   <= '0;
                            trn   <= '0;
                            phase <= '0;
                        end else begin
                            settle_cnt <= settle_cnt + 3'd1;
                        end
                    end
                    ACC: begin
                        // Last cycle of the window: dump and restart with no dead cycle.
                        if (&phase) begin
                            sample       <= clip_count(acc_final);
                            sat          <= (acc_final == CW'(N));
                            stuck        <= (trn_final == '0);
                            sample_valid <= 1'b1;
                            acc          <= '0;
                            trn          <= '0;
                            phase        <= '0;
                        end else begin
                            acc   <= acc_final;
                            trn   <= trn_final;
                            phase <= phase + WIN_LOG2'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ota_bitstream_decimator.sv
// Directed scoreboard bench for ota_bitstream_decimator with WIN_LOG2=4, SYNC_STAGES=2.
module tb_ota_bitstream_decimator;
    localparam int WL = 4;
    localparam int SS = 2;
    localparam int N  = 1 << WL;
`ifdef OTA_DECIM_DEGLITCH_EN
    localparam int DG = 1;
`else
    localparam int DG = 0;
`endif
    localparam int LAT = SS + N + 1 + 2 * DG;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       bit_in = 1'b0;
    logic       en     = 1'b0;
    logic [7:0] sample;
    logic       sample_valid;
    logic       sat;
    logic       stuck;
    logic       busy;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         mode     = 0;
    int         pc       = 0;
    logic [9:0] exp_q[$];
    logic [9:0] mon_e;
    logic [9:0] held;

    ota_bitstream_decimator #(
        .WIN_LOG2   (WL),
        .SYNC_STAGES(SS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_in      (bit_in),
        .en          (en),
        .sample      (sample),
        .sample_valid(sample_valid),
        .sat         (sat),
        .stuck       (stuck),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic pat(input int m, input int i);
        case (m)
            1:       return 1'b1;
            2:       return (i % 2) == 1;
            3:       return (i % 4) == 0;
            4:       return ((i % 16) == 2) || ((i % 16) == 7) || ((i % 16) == 12);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Expected {sample, sat, stuck} for one window of a periodic pattern.
    function automatic logic [9:0] model(input int m);
        int   ones;
        int   trn;
        logic b;
        logic bp;
        ones = 0;
        trn  = 0;
        bp   = 1'b0;
        for (int i = 0; i <= N; i++) begin
            if (DG != 0) b = maj3(pat(m, i + 2), pat(m, i + 1), pat(m, i));
            else         b = pat(m, i + 2);
            if (i > 0) begin
                if (b) ones++;
                if (b != bp) trn++;
            end
            bp = b;
        end
        return {8'((ones >= N) ? N - 1 : ones), ones == N, trn == 0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!sample_valid && k < 4 * N + 40);
        check(tag, k, exp_lat);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 8 * N + 40) begin
            step();
            k++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic push_n(input int m, input int k);
        for (int i = 0; i < k; i++) exp_q.push_back(model(m));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            bit_in = pat(mode, pc);
            pc++;
        end
    end

    always @(negedge clk) begin
        if (sample_valid) begin
            check("pending_expect", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("sample", sample, mon_e[9:2]);
                check("sat", sat, mon_e[1]);
                check("stuck", stuck, mon_e[0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        en    = 1'b0;
        step(); step(); step();
        check("rst_sample", sample, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_sat", sat, 0);
        check("rst_stuck", stuck, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        step();

        // Constant ones: saturated, stuck, valid every N cycles
        mode = 1;
        push_n(1, 3);
        en = 1'b1;
        step();
        check("busy_settle", busy, 1);
        wait_valid("lat_const1", LAT - 1);
        wait_valid("period_const1", N);
        step(); step(); step(); step(); step();
        check("held_sample", sample, model(1) >> 2);
        drain("drain_const1");
        en = 1'b0;
        step(); step();
        check("busy_idle", busy, 0);

        // Toggling every clock: first-valid latency
        mode = 2;
        push_n(2, 2);
        en = 1'b1;
        wait_valid("lat_toggle", LAT);
        drain("drain_toggle");
        en = 1'b0;
        step(); step();

        // Constant zero, then 1-in-4
        mode = 0;
        push_n(0, 2);
        en = 1'b1;
        wait_valid("lat_const0", LAT);
        drain("drain_const0");
        en = 1'b0;
        step(); step();
        mode = 3;
        push_n(3, 2);
        en = 1'b1;
        wait_valid("lat_1in4", LAT);
        drain("drain_1in4");
        en = 1'b0;
        step(); step();

        // Abort a window at phase 9 and restart
        mode = 2;
        push_n(2, 1);
        en = 1'b1;
        wait_valid("lat_pre_abort", LAT);
        held = model(2);
        for (int i = 0; i < 9; i++) step();
        en = 1'b0;
        step();
        check("abort_busy", busy, 0);
        check("abort_sample_hold", sample, held[9:2]);
        step(); step(); step(); step();
        check("abort_stuck_hold", stuck, held[0]);
        push_n(2, 1);
        en = 1'b1;
        wait_valid("lat_after_abort", LAT);
        drain("drain_abort");
        step(); step(); step(); step(); step();

        // Synchronous reset mid-window
        rst_n = 1'b0;
        step();
        check("midrst_sample", sample, 0);
        check("midrst_valid", sample_valid, 0);
        check("midrst_sat", sat, 0);
        check("midrst_stuck", stuck, 0);
        check("midrst_busy", busy, 0);
        rst_n = 1'b1;
        push_n(2, 2);
        wait_valid("lat_after_rst", LAT);
        drain("drain_rst");
        en = 1'b0;
        step(); step();

        // Isolated single-cycle pulses, three per window
        mode = 4;
        push_n(4, 2);
        en = 1'b1;
        wait_valid("lat_pulses", LAT);
        drain("drain_pulses");
        en = 1'b0;
        step(); step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
